// File: rtl/instr_fetch.sv
// Generic FIFO with synchronous clear; head is visible combinationally, zero-cycle read.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop_vld && !empty;
  assign do_push  = push_vld && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      store[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// Instruction fetch with credit-limited request stream, in-order response buffer and static
// backward-branch/JAL prediction; outputs combinational from buffer head, stall holds the head.
module instr_fetch #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] BOOT_PC = '0,
  parameter int              DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_p4_out,
  output logic [XLEN-1:0] instr_out,
  output logic            branch_take_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_use;
  logic [XLEN-1:0]   pcq_head;
  logic              pcq_empty;
  logic [2*XLEN-1:0] rsp_head;
  logic              rsp_empty;

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_arrive;
  logic            rsp_keep;
  logic            head_vld;
  logic            pop;
  logic            take;
  logic            take_pop;
  logic            flush;
  logic            is_jal;
  logic            is_bneg;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   drop_after;

  // Outstanding requests are exactly the PCs waiting in this queue, dropped ones included.
  fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk      (clk),
    .clr      (rst),
    .push_vld (req_fire),
    .push_dat (fetch_pc),
    .pop_vld  (rsp_arrive),
    .head_dat (pcq_head),
    .empty    (pcq_empty),
    .count    (outstanding)
  );

  fifo #(.W(2 * XLEN), .DEPTH(DEPTH)) u_rsp_q (
    .clk      (clk),
    .clr      (flush),
    .push_vld (rsp_keep),
    .push_dat ({pcq_head, imem_rsp_data}),
    .pop_vld  (pop),
    .head_dat (rsp_head),
    .empty    (rsp_empty),
    .count    (fifo_count)
  );

  assign head_pc    = rsp_head[2*XLEN-1:XLEN];
  assign head_instr = rsp_head[XLEN-1:0];

  assign is_jal  = (head_instr[6:0] == 7'b1101111);
  assign is_bneg = (head_instr[6:0] == 7'b1100011) && head_instr[31];
  assign imm_j   = {{(XLEN-20){head_instr[31]}}, head_instr[19:12], head_instr[20],
                    head_instr[30:21], 1'b0};
  assign imm_b   = {{(XLEN-12){head_instr[31]}}, head_instr[7], head_instr[30:25],
                    head_instr[11:8], 1'b0};
  assign target  = head_pc + (is_jal ? imm_j : imm_b);

  assign head_vld = !rst && !rsp_empty;
  assign take     = head_vld && (is_jal || is_bneg);
  assign pop      = head_vld && !stall && !redirect_valid;
  assign take_pop = pop && take;
  assign flush    = rst || redirect_valid || take_pop;

  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok      = in_use < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && !take_pop && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with no matching request (e.g. one left over from before reset) is ignored.
  assign rsp_arrive = !rst && imem_rsp_valid && !pcq_empty;
  assign rsp_keep   = rsp_arrive && (drop_cnt == '0);
  assign drop_after = outstanding - CW'(rsp_arrive);

  assign out_valid       = head_vld;
  assign pc_out          = head_vld ? head_pc : '0;
  assign pc_p4_out       = head_vld ? head_pc + XLEN'(4) : '0;
  assign instr_out       = head_vld ? head_instr : '0;
  assign branch_take_out = take;

  // Redirect outranks a predicted-taken pop; neither issues a request in its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BOOT_PC & ALIGN_MASK;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      drop_cnt <= drop_after;
    end else if (take_pop) begin
      fetch_pc <= target & ALIGN_MASK;
      drop_cnt <= drop_after;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_arrive && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random memory timing, stalls, redirects and resets against an
// architectural fetch-stream model; a negedge monitor pops and checks every delivered word.
module tb_instr_fetch;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_p4_out;
  logic [31:0] instr_out;
  logic        branch_take_out;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(XLEN), .BOOT_PC(BOOT), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .out_valid       (out_valid),
    .pc_out          (pc_out),
    .pc_p4_out       (pc_p4_out),
    .instr_out       (instr_out),
    .branch_take_out (branch_take_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // Program image: the word plus what the generator intended it to do.
  logic [31:0] prog      [64];
  logic        prog_take [64];
  int          prog_off  [64];

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat_max     = 0;
  int pops        = 0;
  int acc_cnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] im;
    logic [4:0]  r1;
    logic [4:0]  r2;
    im = 13'(off);
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] im;
    logic [4:0]  rd;
    im = 21'(off);
    rd = 5'($urandom);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic gen_prog();
    logic [31:0] w;
    int r;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      w[6:0] = 7'b0010011;
      prog[i] = w;
      prog_take[i] = 1'b0;
      prog_off[i] = 4;
      if (i == 4) begin
        prog[i] = 32'hFE00_0EE3;
        prog_take[i] = 1'b1;
        prog_off[i] = -4;
      end else if (i > 4) begin
        r = int'($urandom_range(0, 9));
        if (r == 5 || r == 6) begin
          prog_off[i] = -4 * int'($urandom_range(1, 8));
          prog[i] = enc_b(prog_off[i]);
          prog_take[i] = 1'b1;
        end else if (r == 7) begin
          prog_off[i] = 4 * int'($urandom_range(1, 8));
          prog[i] = enc_b(prog_off[i]);
          prog_take[i] = 1'b0;
        end else if (r == 8) begin
          prog_off[i] = 4 * int'($urandom_range(0, 15)) - 32;
          prog[i] = enc_jal(prog_off[i]);
          prog_take[i] = 1'b1;
        end else if (r == 9) begin
          w = $urandom;
          w[6:0] = 7'b0110011;
          prog[i] = w;
        end
      end
    end
  endtask

  // Architectural instruction stream from a start PC: each word, then its successor PC.
  task automatic refill(input logic [31:0] start);
    logic [31:0] pc;
    int idx;
    exp_q.delete();
    pc = start;
    for (int k = 0; k < 128; k++) begin
      idx = int'(pc[7:2]);
      exp_q.push_back('{pc, prog[idx], prog_take[idx]});
      pc = prog_take[idx] ? pc + 32'(prog_off[idx]) : pc + 32'd4;
    end
  endtask

  // One cycle of stimulus time; the memory model answers in order after its due cycle.
  task automatic step();
    mreq_t m;
    @(posedge clk);
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = prog[m.addr[7:2]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    refill(BOOT);
    repeat (n) step();
    mem_q.delete();
    acc_log.delete();
    acc_cnt = 0;
    imem_rsp_valid = 1'b0;
    rst = 1'b0;
  endtask

  exp_t        e;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        prev_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_pc_instr", {pc_out, instr_out}, 64'd0);
      check("rst_p4_take", {pc_p4_out, 31'd0, branch_take_out}, 64'd0);
      prev_hold = 1'b0;
    end else begin
      if (imem_req_valid) check("req_align", 64'(imem_req_addr[1:0]), 64'd0);
      if (redirect_valid) check("redirect_no_req", 64'(imem_req_valid), 64'd0);
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(0, lat_max))});
        acc_log.push_back(imem_req_addr);
        acc_cnt++;
      end
      if (prev_hold) begin
        check("stall_pc_stable", 64'(pc_out), 64'(prev_pc));
        check("stall_instr_stable", 64'(instr_out), 64'(prev_instr));
      end
      if (!out_valid) check("empty_outputs_zero", {pc_out | pc_p4_out, instr_out}, 64'd0);
      if (out_valid && !stall && !redirect_valid) begin
        pops++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL exp_underflow: got pc %h, expected no delivery", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("pc_out", 64'(pc_out), 64'(e.pc));
          check("instr_out", 64'(instr_out), 64'(e.instr));
          check("pc_p4_out", 64'(pc_p4_out), 64'(e.pc + 32'd4));
          check("branch_take_out", 64'(branch_take_out), 64'(e.take));
          if (e.take) check("taken_pop_no_req", 64'(imem_req_valid), 64'd0);
        end
      end
      prev_hold  = out_valid && stall && !redirect_valid;
      prev_pc    = pc_out;
      prev_instr = instr_out;
    end
  end

  initial begin
    int found;
    int since;
    int stall_left;

    gen_prog();

    // Straight-line fetch with a one-cycle memory.
    imem_req_ready = 1'b1;
    lat_max = 0;
    do_reset(3);
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", 64'(imem_req_addr), 64'(BOOT));
    step();
    step();
    @(negedge clk);
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_pc_out", 64'(pc_out), 64'(BOOT));
    check("first_pc_p4", 64'(pc_p4_out), 64'(BOOT + 32'd4));
    repeat (10) step();
    if (acc_log.size() < 3) begin
      vectors++;
      miscompares++;
      $display("FAIL req_sequence: got %0d requests, expected at least 3", acc_log.size());
    end else begin
      check("req_seq_0", 64'(acc_log[0]), 64'(BOOT));
      check("req_seq_1", 64'(acc_log[1]), 64'(BOOT + 32'd4));
      check("req_seq_2", 64'(acc_log[2]), 64'(BOOT + 32'd8));
    end

    // Stall from release: only DEPTH requests may be accepted.
    stall = 1'b1;
    do_reset(2);
    repeat (6) step();
    check("stall_credit", 64'(acc_cnt), 64'(DEPTH));
    stall = 1'b0;

    // Redirect in the same cycle as a predicted-taken pop (loop at 0x10 branches to 0x0C).
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      step();
      if (out_valid && branch_take_out) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        refill(32'h0000_0100);
        found = 1;
      end
    end
    check("taken_head_seen", 64'(found), 64'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redirect_flush", 64'(out_valid), 64'd0);
    repeat (20) step();

    // Random traffic.
    lat_max = 2;
    since = 0;
    stall_left = 0;
    for (int c = 0; c < 2500; c++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
        since = 0;
      end else begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if (stall_left > 0) begin
          stall = 1'b1;
          stall_left--;
        end else if ($urandom_range(0, 9) == 0) begin
          stall = 1'b1;
          stall_left = int'($urandom_range(0, 4));
        end else begin
          stall = 1'b0;
        end
        since++;
        if (since >= 40 || $urandom_range(0, 24) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc = {22'd0, 8'($urandom_range(0, 80)), 2'b00};
          refill(redirect_pc);
          since = 0;
        end else begin
          redirect_valid = 1'b0;
        end
      end
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    repeat (5) step();
    check("delivery_progress", 64'(pops >= 300), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter BOOT_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 2, response-buffer entries and the maximum number of outstanding requests plus buffered instructions.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request this cycle.
REQ-008 imem_req_addr  out  XLEN  fetch address, word aligned.
REQ-009 imem_rsp_valid  in  1  in-order response valid; cannot be back-pressured.
REQ-010 imem_rsp_data  in  XLEN  returned instruction word.
REQ-011 redirect_valid  in  1  execute-stage misprediction or jump correction.
REQ-012 redirect_pc  in  XLEN  corrected fetch address.
REQ-013 stall  in  1  downstream IF/ID register not enabled; hold output.
REQ-014 out_valid  out  1  pc_out, pc_p4_out, instr_out and branch_take_out are meaningful.
REQ-015 pc_out, pc_p4_out, instr_out  out  XLEN each  head-entry PC, PC+4, instruction word.
REQ-016 branch_take_out  out  1  static prediction for the head instruction: taken.

Function
REQ-017 fetch_pc register: its value drives imem_req_addr, and bits [1:0] are always 0.
REQ-018 imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count) < DEPTH.
REQ-019 Request handshake: a request is accepted when imem_req_valid && imem_req_ready; on accept, fetch_pc += 4 (mod 2^XLEN) and outstanding increments.
REQ-020 Response arrival: outstanding decrements; if drop_cnt > 0, the word is discarded and drop_cnt decrements; otherwise the word is pushed with its PC, taken from an internal in-order PC queue.
REQ-021 FIFO head drives the outputs combinationally; out_valid = fifo non-empty; when empty, all data outputs = 0.
REQ-022 Pop: the head entry pops when out_valid && !stall.
REQ-023 Same-cycle push and pop at full: legal, and count is unchanged; push when full cannot occur, by the credit rule in REQ-018.
REQ-024 pc_p4_out = pc_out + 4, truncated to XLEN.
REQ-025 Static prediction on head, for JAL (opcode 1101111): branch_take_out=1, target = pc_out + J-immediate.
REQ-026 Static prediction on head, for B-type (opcode 1100011) with immediate sign bit instr[31]=1: branch_take_out=1, target = pc_out + B-immediate.
REQ-027 Static prediction on head, for all other instructions: branch_take_out=0.
REQ-028 Predicted-taken pop: fetch_pc := target; all younger FIFO entries are flushed; drop_cnt := outstanding after this cycle's accept/arrival; no request is issued that cycle.
REQ-029 Redirect (redirect_valid=1): fetch_pc := redirect_pc; FIFO is flushed entirely, including the head, with no pop; drop_cnt := outstanding after this cycle's arrival; no request is issued.
REQ-030 Redirect has priority over predicted-taken pop and over stall.
REQ-031 Redirect when outstanding=0: drop_cnt := 0, and fetch resumes at redirect_pc next cycle.
REQ-032 Redirect during a nonzero drop_cnt: drop_cnt is recomputed per REQ-029, never accumulated.
REQ-033 Stall held: outputs are stable, and fetch continues until credit is exhausted.
REQ-034 Counters are sized to hold 0..DEPTH with no wrap; outstanding never exceeds DEPTH.

Reset
REQ-035 While rst=1: fetch_pc=BOOT_PC, fifo_count=0, outstanding=0, drop_cnt=0, imem_req_valid=0, out_valid=0, all data outputs and branch_take_out=0.
REQ-036 Reset mid-operation discards all buffered and in-flight state; responses arriving during reset are ignored.
REQ-037 First request is issued in the cycle after rst deasserts, at BOOT_PC.

Verification
REQ-038 Straight-line fetch: rst release, ready=1, 1-cycle memory -> requests at 0x0,0x4,0x8; out_valid with pc_out=0x0, pc_p4_out=0x4 two cycles after release.
REQ-039 Backpressure: stall=1 for 5 cycles with ready=1 -> at most 2 requests outstanding+buffered; outputs are stable; no lost or duplicated PCs after stall drops.
REQ-040 Backward branch at 0x10: head instr 0xFE000EE3 (beq, offset -4) -> branch_take_out=1, next fetch address 0x0C, and the in-flight word for 0x14 is dropped.
REQ-041 Redirect: redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> FIFO is empty next cycle, both responses are discarded, and the next delivered pc_out=0x100.
REQ-042 Redirect and predicted-taken pop in the same cycle -> the redirect wins, and fetch resumes at redirect_pc.
REQ-043 Reset asserted with 1 outstanding and 1 buffered -> the following response is ignored; after release, the first output is pc_out=BOOT_PC.
